// File: rtl/smmrq_reduce.sv
// smmrq_reduce: small Montgomery reduction stage for the BFV multiply path.
// Takes x in the extended basis Bsk U {m~}, removes the m~ factor and
// returns y_j = (x + q*r) * m~^-1 mod b_j, where r = (x * -q^-1) mod m~.
// One output modulus is processed per cycle through a shared datapath.
module smmrq_reduce #(
  parameter int RES_W = 32,
  parameter int OUT_BASIS_LEN = 3,
  parameter logic [OUT_BASIS_LEN-1:0][RES_W-1:0] OUT_BASIS      = {32'd13, 32'd11, 32'd7},
  parameter logic [RES_W-1:0]                    MT             = 32'd16,
  parameter logic [RES_W-1:0]                    NEG_QINV_MOD_MT = 32'd1,
  parameter logic [OUT_BASIS_LEN-1:0][RES_W-1:0] Q_MOD_OUT      = {32'd2, 32'd4, 32'd1},
  parameter logic [OUT_BASIS_LEN-1:0][RES_W-1:0] MT_INV_MOD_OUT = {32'd9, 32'd9, 32'd4}
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [OUT_BASIS_LEN-1:0][RES_W-1:0]  input_RNSint,
  input  logic [RES_W-1:0]                     input_mt,
  output logic                                 out_valid,
  output logic [OUT_BASIS_LEN-1:0][RES_W-1:0]  output_RNSint
);

  localparam int WIDE_W = 2 * RES_W;
  localparam int JW = (OUT_BASIS_LEN > 1) ? $clog2(OUT_BASIS_LEN) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(OUT_BASIS_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_R = 2'd1,
    LOOP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic [JW-1:0]                     j_q, j_d;
  logic [RES_W-1:0]                  r_q, r_d;
  logic [RES_W-1:0]                  mt_q, mt_d;
  logic [OUT_BASIS_LEN-1:0][RES_W-1:0] x_q, x_d;
  logic [OUT_BASIS_LEN-1:0][RES_W-1:0] y_q, y_d;

  logic              accept_s;
  logic              last_s;
  logic [RES_W-1:0]  b_s;
  logic [RES_W-1:0]  xj_s;
  logic [WIDE_W-1:0] sum_s;
  logic [RES_W-1:0]  sum_red_s;
  logic [WIDE_W-1:0] prod2_s;
  logic [RES_W-1:0]  yj_s;

  assign accept_s = (state_q == IDLE) && in_valid;
  assign last_s   = (j_q == J_LAST);

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign output_RNSint = y_q;

  // State and handshake output registers; reset wins over any input
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath registers: latched inputs, r, modulus index and results
  always_ff @(posedge clk) begin
    if (!reset) begin
      j_q  <= '0;
      r_q  <= '0;
      mt_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      j_q  <= j_d;
      r_q  <= r_d;
      mt_q <= mt_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // Next-state logic: IDLE -> CALC_R -> LOOP (one modulus per cycle) -> DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = CALC_R;
        end else begin
          state_d = IDLE;
        end
      end
      CALC_R: begin
        state_d = LOOP;
      end
      LOOP: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = LOOP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered, so derive them from the next state
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Shared multiply/reduce for the current modulus j; r is < m~ and is used
  // unreduced against b_j because the product is formed at double width
  always_comb begin
    b_s       = OUT_BASIS[j_q];
    xj_s      = x_q[j_q];
    sum_s     = (WIDE_W'(Q_MOD_OUT[j_q]) * WIDE_W'(r_q)) + WIDE_W'(xj_s);
    sum_red_s = RES_W'(sum_s % WIDE_W'(b_s));
    prod2_s   = WIDE_W'(sum_red_s) * WIDE_W'(MT_INV_MOD_OUT[j_q]);
    yj_s      = RES_W'(prod2_s % WIDE_W'(b_s));
  end

  // Datapath next values for each state
  always_comb begin
    j_d  = j_q;
    r_d  = r_q;
    mt_d = mt_q;
    x_d  = x_q;
    y_d  = y_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          x_d  = input_RNSint;
          mt_d = input_mt;
          j_d  = '0;
        end else begin
          j_d  = j_q;
        end
      end
      CALC_R: begin
        r_d = RES_W'((WIDE_W'(mt_q) * WIDE_W'(NEG_QINV_MOD_MT)) % WIDE_W'(MT));
      end
      LOOP: begin
        y_d[j_q] = yj_s;
        if (last_s) begin
          j_d = '0;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DONE: begin
        j_d = '0;
      end
      default: begin
        j_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_smmrq_reduce.sv
// Self-checking bench for smmrq_reduce: directed checks on a small basis
// plus 100 random 256-bit integers on a second, larger basis. Expected
// outputs come from the integer identity y_j = ((x + q*r) / m~) mod b_j.
module tb_smmrq_reduce;

  // ---------------- constant helpers for the random basis ----------------
  function automatic logic [31:0] pow_mod(input logic [63:0] a, input logic [63:0] e,
                                          input logic [63:0] m);
    logic [63:0] res;
    logic [63:0] base;
    res  = 64'd1;
    base = a % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) res = (res * base) % m;
      base = (base * base) % m;
    end
    return res[31:0];
  endfunction

  localparam logic [63:0]       RQ      = 64'h1FFF_FFFF_FFFF_FFFF;  // q = 2^61-1
  localparam logic [31:0]       RMT     = 32'd997;
  localparam logic [3:0][31:0]  R_BASIS = {32'd1009, 32'd1013, 32'd1019, 32'd1021};

  function automatic logic [3:0][31:0] mk_qmod();
    logic [3:0][31:0] v;
    logic [63:0] t;
    for (int j = 0; j < 4; j++) begin
      t = RQ % {32'd0, R_BASIS[j]};
      v[j] = t[31:0];
    end
    return v;
  endfunction

  function automatic logic [3:0][31:0] mk_mtinv();
    logic [3:0][31:0] v;
    for (int j = 0; j < 4; j++)
      v[j] = pow_mod({32'd0, RMT}, {32'd0, R_BASIS[j]} - 64'd2, {32'd0, R_BASIS[j]});
    return v;
  endfunction

  function automatic logic [31:0] mk_negqinv();
    logic [31:0] qi;
    qi = pow_mod(RQ % {32'd0, RMT}, {32'd0, RMT} - 64'd2, {32'd0, RMT});
    return (RMT - qi) % RMT;
  endfunction

  localparam logic [3:0][31:0] R_QMOD  = mk_qmod();
  localparam logic [3:0][31:0] R_MTINV = mk_mtinv();
  localparam logic [31:0]      R_NEGQ  = mk_negqinv();

  localparam logic [2:0][31:0] D_BASIS = {32'd13, 32'd11, 32'd7};
  localparam int               D_N     = 3;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mod256(input logic [255:0] x, input logic [31:0] m);
    logic [255:0] t;
    t = x % {224'd0, m};
    return t[31:0];
  endfunction

  // (x + q*r) is a multiple of m~, so the exact quotient reduced mod b equals y
  function automatic logic [31:0] golden_y(input logic [255:0] x, input logic [63:0] q,
                                           input logic [31:0] mt, input logic [31:0] negq,
                                           input logic [31:0] b);
    logic [63:0]  r;
    logic [319:0] s;
    logic [319:0] t;
    r = ({32'd0, mod256(x, mt)} * {32'd0, negq}) % {32'd0, mt};
    s = {64'd0, x} + ({256'd0, q} * {256'd0, r});
    t = (s / {288'd0, mt}) % {288'd0, b};
    return t[31:0];
  endfunction

  // ---------------- DUT wiring ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             d_reset, d_in_valid, d_in_ready, d_out_valid;
  logic [2:0][31:0] d_in_x, d_out;
  logic [31:0]      d_in_mt;

  logic             r_reset, r_in_valid, r_in_ready, r_out_valid;
  logic [3:0][31:0] r_in_x, r_out;
  logic [31:0]      r_in_mt;

  smmrq_reduce #(
    .RES_W(32), .OUT_BASIS_LEN(3),
    .OUT_BASIS({32'd13, 32'd11, 32'd7}), .MT(32'd16), .NEG_QINV_MOD_MT(32'd1),
    .Q_MOD_OUT({32'd2, 32'd4, 32'd1}), .MT_INV_MOD_OUT({32'd9, 32'd9, 32'd4})
  ) u_dir (
    .clk(clk), .reset(d_reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .input_RNSint(d_in_x), .input_mt(d_in_mt),
    .out_valid(d_out_valid), .output_RNSint(d_out)
  );

  smmrq_reduce #(
    .RES_W(32), .OUT_BASIS_LEN(4),
    .OUT_BASIS(R_BASIS), .MT(RMT), .NEG_QINV_MOD_MT(R_NEGQ),
    .Q_MOD_OUT(R_QMOD), .MT_INV_MOD_OUT(R_MTINV)
  ) u_rnd (
    .clk(clk), .reset(r_reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .input_RNSint(r_in_x), .input_mt(r_in_mt),
    .out_valid(r_out_valid), .output_RNSint(r_out)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0][31:0] d_exp_q[$];
  logic [3:0][31:0] r_exp_q[$];
  int d_acc = 0, d_outs = 0, r_acc = 0, r_outs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Directed-instance monitor: pop one expected vector per out_valid pulse
  always @(negedge clk) begin
    logic [2:0][31:0] e;
    if (d_reset && d_out_valid) begin
      d_outs++;
      if (d_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_unexpected_out_valid: got out_valid=1 expected no result");
      end else begin
        e = d_exp_q.pop_front();
        for (int j = 0; j < 3; j++) chk($sformatf("d_y%0d", j), {32'd0, d_out[j]}, {32'd0, e[j]});
      end
    end
  end

  // Random-instance monitor
  always @(negedge clk) begin
    logic [3:0][31:0] e;
    if (r_reset && r_out_valid) begin
      r_outs++;
      if (r_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected_out_valid: got out_valid=1 expected no result");
      end else begin
        e = r_exp_q.pop_front();
        for (int j = 0; j < 4; j++) chk($sformatf("r_y%0d", j), {32'd0, r_out[j]}, {32'd0, e[j]});
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic d_drive(input logic [255:0] x, input bit expect_out);
    logic [2:0][31:0] e;
    for (int j = 0; j < 3; j++) begin
      d_in_x[j] = mod256(x, D_BASIS[j]);
      e[j]      = golden_y(x, 64'd15, 32'd16, 32'd1, D_BASIS[j]);
    end
    d_in_mt    = mod256(x, 32'd16);
    d_in_valid = 1'b1;
    if (expect_out) begin
      d_exp_q.push_back(e);
      d_acc++;
    end
  endtask

  task automatic d_wait_ready(input string name);
    int n;
    n = 0;
    while (!d_in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, {63'd0, d_in_ready}, 64'd1);
  endtask

  // Send one vector and measure the cycles until out_valid
  task automatic d_send(input logic [255:0] x);
    int n;
    d_wait_ready("d_ready_before_send");
    d_drive(x, 1'b1);
    @(negedge clk);
    d_in_valid = 1'b0;
    n = 1;
    while (!d_out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    // DONE is the (N+3)th cycle counting the accepting IDLE cycle
    chk("d_cycles_to_out_valid", n, D_N + 2);
    @(negedge clk);
    chk("d_out_valid_one_cycle", {63'd0, d_out_valid}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] x;
    int n;
    d_reset = 1'b0; d_in_valid = 1'b0; d_in_x = '0; d_in_mt = 32'd0;
    r_reset = 1'b0; r_in_valid = 1'b0; r_in_x = '0; r_in_mt = 32'd0;
    repeat (3) @(negedge clk);
    chk("d_reset_in_ready", {63'd0, d_in_ready}, 64'd1);
    chk("d_reset_out_valid", {63'd0, d_out_valid}, 64'd0);
    chk("d_reset_output", {32'd0, d_out[0] | d_out[1] | d_out[2]}, 64'd0);
    chk("r_reset_in_ready", {63'd0, r_in_ready}, 64'd1);
    d_reset = 1'b1;
    r_reset = 1'b1;
    @(negedge clk);

    // x = 37 -> {0,7,7}
    d_send(256'd37);

    // Reset pulled low while j == 1: result abandoned, registers cleared
    d_wait_ready("d_ready_before_reset_test");
    d_drive(256'd37, 1'b0);
    @(negedge clk); d_in_valid = 1'b0;   // CALC_R
    @(negedge clk);                      // LOOP j=0
    @(negedge clk); d_reset = 1'b0;      // LOOP j=1
    @(negedge clk); d_reset = 1'b1;
    chk("d_after_reset_in_ready", {63'd0, d_in_ready}, 64'd1);
    chk("d_after_reset_out_valid", {63'd0, d_out_valid}, 64'd0);
    chk("d_after_reset_y1", {32'd0, d_out[1]}, 64'd0);
    chk("d_after_reset_y2", {32'd0, d_out[2]}, 64'd0);
    repeat (8) @(negedge clk);

    // Reset coinciding with in_valid drops the input
    d_drive(256'd37, 1'b0);
    d_reset = 1'b0;
    @(negedge clk);
    d_reset = 1'b1; d_in_valid = 1'b0;
    @(negedge clk);
    chk("d_reset_priority_in_ready", {63'd0, d_in_ready}, 64'd1);
    repeat (8) @(negedge clk);

    // Fresh vector after reset, then all-zero input
    d_send(256'd37);
    d_send(256'd0);

    // Back-to-back: second vector held valid while busy
    d_wait_ready("d_ready_before_b2b");
    d_drive(256'd37, 1'b1);
    @(negedge clk);
    d_drive(256'd0, 1'b0);
    n = 0;
    while (!d_in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("d_b2b_busy_cycles", n, D_N + 2);
    d_drive(256'd0, 1'b1);
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Random vectors on the larger basis
    for (int t = 0; t < 100; t++) begin
      logic [3:0][31:0] e;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n = 0;
      while (!r_in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("r_ready_before_send", {63'd0, r_in_ready}, 64'd1);
      for (int k = 0; k < 8; k++) x[k*32 +: 32] = $urandom;
      for (int j = 0; j < 4; j++) begin
        r_in_x[j] = mod256(x, R_BASIS[j]);
        e[j]      = golden_y(x, RQ, RMT, R_NEGQ, R_BASIS[j]);
      end
      r_in_mt    = mod256(x, RMT);
      r_in_valid = 1'b1;
      r_exp_q.push_back(e);
      r_acc++;
      @(negedge clk);
      // Keep in_valid high with junk while busy; it must be ignored
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 4; j++) r_in_x[j] = $urandom;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      r_in_valid = 1'b0;
    end

    n = 0;
    while ((d_exp_q.size() != 0 || r_exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("d_pending_results", d_exp_q.size(), 64'd0);
    chk("r_pending_results", r_exp_q.size(), 64'd0);
    chk("d_out_valid_per_accept", d_outs, d_acc);
    chk("r_out_valid_per_accept", r_outs, 64'd100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
